// File: rtl/fb_port_if.sv
// fb_port_if: frame-buffer arbiter bus bundle covering the VGA read port,
// the camera write port and the single BRAM port.
interface fb_port_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    logic              vga_re;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              cam_we;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_wdata;
    logic              cam_full;
    logic              cam_ovf;
    logic              ovf_clr;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output vga_re, vga_addr, cam_we, cam_addr, cam_wdata, ovf_clr, mem_rdata,
        input  vga_rdata, vga_rvalid, cam_full, cam_ovf, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  vga_re, vga_addr, cam_we, cam_addr, cam_wdata, ovf_clr, mem_rdata,
        output vga_rdata, vga_rvalid, cam_full, cam_ovf, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: single-port frame-buffer sharing; VGA reads win, camera
// writes queue in a FIFO and drain on cycles the reader leaves free.
module fb_port_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    fb_port_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count, count_next;
    logic [ADDR_W-1:0] last_addr;
    logic              last_valid;
    logic [DATA_W-1:0] hold;
    logic              v1, h1, v2, h2;
    logic              empty, full, hit, rd_miss, drain, push;

    // A pending write to the requested address forces a real RAM read
    always_comb begin
        empty      = count == '0;
        full       = count == FULL;
        hit        = last_valid && bus.vga_addr == last_addr &&
                     !(!empty && fifo_addr[rd_ptr] == bus.vga_addr);
        rd_miss    = bus.vga_re && !hit;
        drain      = !rd_miss && !empty;
        push       = bus.cam_we && !full;
        count_next = count + (PW+1)'(push) - (PW+1)'(drain);
    end

    always_ff @(posedge clk)
        if (push) begin
            fifo_addr[wr_ptr] <= bus.cam_addr;
            fifo_data[wr_ptr] <= bus.cam_wdata;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            last_addr     <= '0;
            last_valid    <= 1'b0;
            hold          <= '0;
            v1            <= 1'b0;
            h1            <= 1'b0;
            v2            <= 1'b0;
            h2            <= 1'b0;
            bus.cam_full  <= 1'b0;
            bus.cam_ovf   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            wr_ptr       <= wr_ptr + PW'(push);
            rd_ptr       <= rd_ptr + PW'(drain);
            count        <= count_next;
            bus.cam_full <= count_next == FULL;
            bus.cam_ovf  <= (bus.cam_we && full) || (bus.cam_ovf && !bus.ovf_clr);
            bus.mem_en   <= rd_miss || drain;
            bus.mem_we   <= drain;
            if (rd_miss || drain)
                bus.mem_addr <= rd_miss ? bus.vga_addr : fifo_addr[rd_ptr];
            if (drain)
                bus.mem_wdata <= fifo_data[rd_ptr];
            if (rd_miss) begin
                last_addr  <= bus.vga_addr;
                last_valid <= 1'b1;
            end else if (drain && fifo_addr[rd_ptr] == last_addr)
                last_valid <= 1'b0;
            v1 <= bus.vga_re;
            h1 <= hit;
            v2 <= v1;
            h2 <= h1;
            if (v2 && !h2)
                hold <= bus.mem_rdata;
        end

    // Miss data comes straight from the RAM in its return cycle
    assign bus.vga_rvalid = v2;
    assign bus.vga_rdata  = v2 ? (h2 ? hold : bus.mem_rdata) : '0;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: random and directed traffic against a queue-based
// model of the arbiter, with a BRAM model attached to the memory port.
module tb_fb_port_arbiter;
    localparam int AW = 17, DW = 12, DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fb_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [DW-1:0] bram [2**AW];
    always @(posedge clk)
        if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= bram[bus.mem_addr];
        end

    // Model: memory image, FIFO as queues, last-read tracking, result pipe
    logic [DW-1:0] img [2**AW];
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    bit            m_lv, m_full, m_ovf, e_en, e_we;
    logic [AW-1:0] m_la, e_addr;
    logic [DW-1:0] m_hold, e_wdata;
    bit            p_v [2];
    logic [DW-1:0] p_d [2];

    int checks = 0, errors = 0;
    int n_rd, n_wr;
    logic [15:0] rmask, wmask;
    logic [DW-1:0] obs[$];
    int ra_prev;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("vga_rvalid", bus.vga_rvalid, p_v[0]);
        if (p_v[0]) chk("vga_rdata", bus.vga_rdata, p_d[0]);
        chk("mem_en", bus.mem_en, e_en);
        chk("mem_we", bus.mem_we, e_we);
        if (e_en) chk("mem_addr", bus.mem_addr, e_addr);
        if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("cam_full", bus.cam_full, m_full);
        chk("cam_ovf", bus.cam_ovf, m_ovf);
        if (bus.vga_rvalid) obs.push_back(bus.vga_rdata);
        n_rd += int'(bus.mem_en && !bus.mem_we);
        n_wr += int'(bus.mem_we);
        rmask = {rmask[14:0], bus.mem_en & ~bus.mem_we};
        wmask = {wmask[14:0], bus.mem_we};
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        m_lv = 0; m_full = 0; m_ovf = 0; e_en = 0; e_we = 0;
        p_v[0] = 0; p_v[1] = 0;
    endtask

    task automatic decide();
        bit empty, full, hit, miss;
        empty = q_addr.size() == 0;
        full  = q_addr.size() == DEPTH;
        hit   = m_lv && bus.vga_addr == m_la && !(!empty && q_addr[0] == bus.vga_addr);
        miss  = bus.vga_re && !hit;
        p_v[0] = p_v[1];
        p_d[0] = p_d[1];
        e_en = 0;
        e_we = 0;
        if (miss) begin
            e_en = 1; e_addr = bus.vga_addr;
            m_hold = img[bus.vga_addr];
            m_la = bus.vga_addr; m_lv = 1;
        end else if (!empty) begin
            e_en = 1; e_we = 1;
            e_addr = q_addr.pop_front();
            e_wdata = q_data.pop_front();
            img[e_addr] = e_wdata;
            if (e_addr == m_la) m_lv = 0;
        end
        p_v[1] = bus.vga_re;
        p_d[1] = m_hold;
        if (bus.ovf_clr) m_ovf = 0;
        if (bus.cam_we) begin
            if (full) m_ovf = 1;
            else begin
                q_addr.push_back(bus.cam_addr);
                q_data.push_back(bus.cam_wdata);
            end
        end
        m_full = q_addr.size() == DEPTH;
    endtask

    task automatic cyc(bit re, int ra, bit we, int wa, int wd, bit clr);
        @(negedge clk);
        compare();
        bus.vga_re = re; bus.vga_addr = AW'(ra);
        bus.cam_we = we; bus.cam_addr = AW'(wa); bus.cam_wdata = DW'(wd);
        bus.ovf_clr = clr;
        decide();
    endtask

    task automatic idle(int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_values(string tag);
        chk({tag, "_mem_en"}, bus.mem_en, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_vga_rvalid"}, bus.vga_rvalid, 0);
        chk({tag, "_vga_rdata"}, bus.vga_rdata, 0);
        chk({tag, "_cam_full"}, bus.cam_full, 0);
        chk({tag, "_cam_ovf"}, bus.cam_ovf, 0);
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        compare();
        rst_n = 0;
        bus.vga_re = 0; bus.cam_we = 0; bus.ovf_clr = 0;
        model_reset();
        #1 reset_values("rst_mid");
        repeat (n) begin @(negedge clk); compare(); end
        rst_n = 1;
        decide();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.vga_re = 0; bus.vga_addr = '0; bus.cam_we = 0; bus.cam_addr = '0;
        bus.cam_wdata = '0; bus.ovf_clr = 0;
        model_reset();
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        reset_values("rst_init");
        rst_n = 1;
        decide();

        // Fill the readable region through the write path
        for (int a = 0; a < 64; a++) cyc(0, 0, 1, a, int'($urandom_range(0, 4095)), 0);
        cyc(0, 0, 1, 'h10, 'hABC, 0);
        cyc(0, 0, 1, 'h11, 'h123, 0);
        cyc(0, 0, 1, 'h20, 'h111, 0);
        idle(3);

        // Miss/hit pair
        obs.delete(); n_rd = 0;
        cyc(1, 'h10, 0, 0, 0, 0);
        cyc(1, 'h10, 0, 0, 0, 0);
        cyc(1, 'h11, 0, 0, 0, 0);
        cyc(1, 'h11, 0, 0, 0, 0);
        idle(3);
        chk("pair_ram_reads", n_rd, 2);
        chk("pair_count", obs.size(), 4);
        chk("pair_d0", obs[0], 'hABC);
        chk("pair_d1", obs[1], 'hABC);
        chk("pair_d2", obs[2], 'h123);
        chk("pair_d3", obs[3], 'h123);

        // Writes drain only in hit slots
        rmask = '0; wmask = '0;
        for (int i = 0; i < 8; i++)
            cyc(1, 'h40 + i / 2, int'(i < 4), 'h100 + i, 'h700 + i, 0);
        idle(2);
        chk("slot_wmask", wmask, 16'h00AA);
        chk("slot_rmask", rmask, 16'h0154);
        chk("slot_full", bus.cam_full, 0);

        // Overflow with every cycle taken by unique reads
        n_wr = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, i, 1, 'h100 + i, 'h500 + i, 0);
            after_edge();
            chk($sformatf("ovf_full_%0d", i), bus.cam_full, int'(i >= 7));
            chk($sformatf("ovf_flag_%0d", i), bus.cam_ovf, int'(i == 8));
        end
        cyc(1, 9, 0, 0, 0, 1);
        after_edge();
        chk("ovf_cleared", bus.cam_ovf, 0);
        chk("ovf_no_drain", n_wr, 0);
        idle(10);
        chk("ovf_drained", n_wr, 8);

        // Invalidation by a drained write
        obs.delete();
        cyc(1, 'h20, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 'h20, 'h222, 0);
        idle(2);
        n_rd = 0;
        cyc(1, 'h20, 0, 0, 0, 0);
        idle(3);
        chk("inv_count", obs.size(), 2);
        chk("inv_old", obs[0], 'h111);
        chk("inv_new", obs[1], 'h222);
        chk("inv_reread", n_rd, 1);

        // Head conflict
        cyc(1, 'h30, 1, 'h30, 'h333, 0);
        cyc(1, 'h30, 0, 0, 0, 0);
        after_edge();
        chk("head_en", bus.mem_en, 1);
        chk("head_we", bus.mem_we, 0);
        chk("head_addr", bus.mem_addr, 'h30);
        idle(3);
        obs.delete();
        cyc(1, 'h30, 0, 0, 0, 0);
        idle(3);
        chk("head_after", obs[0], 'h333);

        // Reset mid-burst
        cyc(1, 'h0A, 1, 'h120, 'h1, 0);
        cyc(1, 'h0B, 1, 'h121, 'h2, 0);
        cyc(1, 'h0C, 0, 0, 0, 0);
        obs.delete(); n_wr = 0;
        do_reset(2);
        idle(4);
        chk("rst_results", obs.size(), 1);
        chk("rst_fifo_empty", n_wr, 0);
        chk("rst_full", bus.cam_full, 0);

        // Random 2x-upscale-like traffic
        ra_prev = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(1);
            if ($urandom_range(0, 9) < 4) ra_prev = int'($urandom_range(0, 31));
            cyc($urandom_range(0, 9) < 8, ra_prev,
                $urandom_range(0, 9) < ((i / 300) % 2 == 1 ? 9 : 3),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 4095)),
                $urandom_range(0, 19) == 0);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
